// File: rtl/conflict_monitor_pkg.sv
// Shared definitions for the traffic-light conflict monitor: lamp indices,
// failsafe patterns, fault codes and controller states.
package conflict_monitor_pkg;

    localparam int MAIN_G = 6;
    localparam int MAIN_Y = 5;
    localparam int MAIN_R = 4;
    localparam int SIDE_G = 3;
    localparam int SIDE_Y = 2;
    localparam int SIDE_R = 1;
    localparam int WALK   = 0;

    localparam logic [6:0] ALL_RED = 7'b0010010;
    localparam logic [6:0] ALL_OFF = 7'b0000000;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_CONFLICT = 3'd1;
    localparam logic [2:0] FC_HEAD     = 3'd2;
    localparam logic [2:0] FC_WALK     = 3'd3;
    localparam logic [2:0] FC_STUCK    = 3'd4;

    typedef enum logic [1:0] {
        MONITOR   = 2'd0,
        PENDING   = 2'd1,
        FAULT_ON  = 2'd2,
        FAULT_OFF = 2'd3
    } state_e;

endpackage

// File: rtl/conflict_monitor_if.sv
// Lamp/tick/ack bundle between the traffic-light FSM side and the monitor.
interface conflict_monitor_if;

    logic       tickIn;
    logic [6:0] lightsIn;
    logic       ackIn;
    logic [6:0] lightsOut;
    logic       faultOut;
    logic [2:0] faultCode;

    modport master (
        output tickIn, lightsIn, ackIn,
        input  lightsOut, faultOut, faultCode
    );

    modport slave (
        input  tickIn, lightsIn, ackIn,
        output lightsOut, faultOut, faultCode
    );

endinterface

// File: rtl/conflict_monitor_lamp_legality_check.sv
// Purely combinational lamp-vector legality check returning the
// lowest-numbered (highest-priority) violation code.
module lamp_legality_check
    import conflict_monitor_pkg::*;
(
    input  logic [6:0] lights_i,
    output logic       legal_o,
    output logic [2:0] code_o
);

    function automatic logic exactly_one(input logic g, input logic y, input logic r);
        return (g ^ y ^ r) & ~(g & y & r);
    endfunction

    logic conflict;
    logic head_bad;
    logic walk_bad;

    assign conflict = (lights_i[MAIN_G] | lights_i[MAIN_Y]) &
                      (lights_i[SIDE_G] | lights_i[SIDE_Y]);
    assign head_bad = ~exactly_one(lights_i[MAIN_G], lights_i[MAIN_Y], lights_i[MAIN_R]) |
                      ~exactly_one(lights_i[SIDE_G], lights_i[SIDE_Y], lights_i[SIDE_R]);
    assign walk_bad = lights_i[WALK] & (~lights_i[MAIN_R] | ~lights_i[SIDE_R]);

    always_comb begin
        code_o = FC_NONE;
        if (conflict)      code_o = FC_CONFLICT;
        else if (head_bad) code_o = FC_HEAD;
        else if (walk_bad) code_o = FC_WALK;
    end

    assign legal_o = ~(conflict | head_bad | walk_bad);

endmodule

// File: rtl/conflict_monitor.sv
// Safety stage after the traffic-light FSM: forwards lamps with one cycle of
// latency, and latches a flashing all-red failsafe on illegal or frozen output.
module conflict_monitor
    import conflict_monitor_pkg::*;
#(
    parameter int FILTER_CYCLES   = 4,
    parameter int MAX_STUCK_TICKS = 120
) (
    input  logic               clk,
    input  logic               globalReset,
    conflict_monitor_if.slave  bus
);

    localparam int FILT_W  = $clog2(FILTER_CYCLES + 1);
    localparam int STUCK_W = $clog2(MAX_STUCK_TICKS + 1);

    localparam logic [FILT_W-1:0]  FILT_LAST  = FILT_W'(FILTER_CYCLES);
    localparam logic [FILT_W-1:0]  FILT_ONE   = FILT_W'(1);
    localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(MAX_STUCK_TICKS);
    localparam logic [STUCK_W-1:0] STUCK_ONE  = STUCK_W'(1);
    localparam logic [STUCK_W-1:0] STUCK_SAT  = '1;

    state_e             state_q, state_d;
    logic [FILT_W-1:0]  filt_q, filt_d;
    logic [STUCK_W-1:0] stuck_q, stuck_d;
    logic [6:0]         last_q, last_d;
    logic [6:0]         lights_q, lights_d;
    logic               fault_q, fault_d;
    logic [2:0]         code_q, code_d;

    logic               legal;
    logic [2:0]         code;
    logic [FILT_W-1:0]  filt_inc;
    logic               combo_fire;
    logic               stuck_fire;

    // One checker serves both the violation filter and the acknowledge gate.
    lamp_legality_check u_legal (
        .lights_i (bus.lightsIn),
        .legal_o  (legal),
        .code_o   (code)
    );

    always_comb begin
        state_d    = state_q;
        filt_d     = filt_q;
        stuck_d    = stuck_q;
        last_d     = last_q;
        lights_d   = lights_q;
        fault_d    = fault_q;
        code_d     = code_q;
        filt_inc   = (state_q == PENDING) ? filt_q + FILT_ONE : FILT_ONE;
        combo_fire = 1'b0;
        stuck_fire = 1'b0;

        case (state_q)
            MONITOR, PENDING: begin
                lights_d = bus.lightsIn;
                if (bus.lightsIn != last_q) begin
                    last_d  = bus.lightsIn;
                    stuck_d = '0;
                end else if (bus.tickIn && stuck_q != STUCK_SAT) begin
                    stuck_d = stuck_q + STUCK_ONE;
                end

                if (!legal) begin
                    state_d = PENDING;
                    filt_d  = filt_inc;
                end else begin
                    state_d = MONITOR;
                    filt_d  = '0;
                end

                // The stuck watchdog acts on last cycle's count, hence one cycle late.
                combo_fire = !legal && (filt_inc == FILT_LAST);
                stuck_fire = (stuck_q >= STUCK_LAST);
                if (combo_fire || stuck_fire) begin
                    state_d  = FAULT_ON;
                    fault_d  = 1'b1;
                    code_d   = combo_fire ? code : FC_STUCK;
                    lights_d = ALL_RED;
                    filt_d   = '0;
                end
            end

            FAULT_ON, FAULT_OFF: begin
                if (bus.ackIn && legal) begin
                    state_d  = MONITOR;
                    fault_d  = 1'b0;
                    code_d   = FC_NONE;
                    stuck_d  = '0;
                    filt_d   = '0;
                    last_d   = bus.lightsIn;
                    lights_d = bus.lightsIn;
                end else if (bus.tickIn) begin
                    state_d  = (state_q == FAULT_ON) ? FAULT_OFF : FAULT_ON;
                    lights_d = (state_q == FAULT_ON) ? ALL_OFF : ALL_RED;
                end
            end

            default: begin
                state_d = MONITOR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge globalReset) begin
        if (globalReset) begin
            state_q  <= MONITOR;
            filt_q   <= '0;
            stuck_q  <= '0;
            last_q   <= ALL_RED;
            lights_q <= ALL_RED;
            fault_q  <= 1'b0;
            code_q   <= FC_NONE;
        end else begin
            state_q  <= state_d;
            filt_q   <= filt_d;
            stuck_q  <= stuck_d;
            last_q   <= last_d;
            lights_q <= lights_d;
            fault_q  <= fault_d;
            code_q   <= code_d;
        end
    end

    assign bus.lightsOut = lights_q;
    assign bus.faultOut  = fault_q;
    assign bus.faultCode = code_q;

endmodule

// File: tb/tb_conflict_monitor.sv
// Scoreboard bench for conflict_monitor: a behavioural lamp-safety model
// predicts each cycle's outputs, and a monitor compares them after each edge.
module tb_conflict_monitor;

    localparam int FILT  = 4;
    localparam int MAX_T = 120;
    localparam logic [6:0] RED    = 7'b0010010;
    localparam logic [6:0] MAIN_G = 7'b1000010;
    localparam logic [6:0] MAIN_Y = 7'b0100010;
    localparam logic [6:0] BOTH_G = 7'b1001000;

    logic clk = 1'b0;
    logic globalReset = 1'b0;
    always #5 clk = ~clk;

    conflict_monitor_if bus();

    conflict_monitor #(
        .FILTER_CYCLES   (FILT),
        .MAX_STUCK_TICKS (MAX_T)
    ) dut (
        .clk         (clk),
        .globalReset (globalReset),
        .bus         (bus)
    );

    typedef struct {
        logic [6:0] lights;
        logic       fault;
        logic [2:0] code;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: plain counters and flags.
    bit         m_fault;
    bit         m_on;
    int         m_code;
    int         m_filt;
    int         m_stuck;
    logic [6:0] m_last;
    logic [6:0] m_out;

    logic [6:0] pool [0:6];

    function automatic int ref_code(input logic [6:0] l);
        int m_cnt;
        int s_cnt;
        m_cnt = int'(l[6]) + int'(l[5]) + int'(l[4]);
        s_cnt = int'(l[3]) + int'(l[2]) + int'(l[1]);
        if ((l[6] || l[5]) && (l[3] || l[2])) return 1;
        if (m_cnt != 1 || s_cnt != 1) return 2;
        if (l[0] && (!l[4] || !l[1])) return 3;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s t=%0t got %0h want %0h", name, $time, got, want);
        end
    endtask

    task automatic model_apply(input logic [6:0] l, input bit t, input bit a);
        int   c;
        bit   combo;
        bit   stuck_hit;
        exp_t e;
        c = ref_code(l);
        combo = 1'b0;
        if (!m_fault) begin
            stuck_hit = (m_stuck >= MAX_T);
            if (c != 0) begin
                m_filt++;
                combo = (m_filt >= FILT);
            end else begin
                m_filt = 0;
            end
            if (l != m_last) begin
                m_last  = l;
                m_stuck = 0;
            end else if (t) begin
                m_stuck++;
            end
            if (combo || stuck_hit) begin
                m_fault = 1'b1;
                m_on    = 1'b1;
                m_code  = combo ? c : 4;
                m_filt  = 0;
                m_out   = RED;
            end else begin
                m_out = l;
            end
        end else if (a && c == 0) begin
            m_fault = 1'b0;
            m_code  = 0;
            m_stuck = 0;
            m_filt  = 0;
            m_last  = l;
            m_out   = l;
        end else if (t) begin
            m_on  = !m_on;
            m_out = m_on ? RED : 7'b0000000;
        end
        e.lights = m_out;
        e.fault  = m_fault;
        e.code   = 3'(m_code);
        q.push_back(e);
    endtask

    task automatic step(input logic [6:0] l, input bit t, input bit a);
        @(negedge clk);
        bus.lightsIn = l;
        bus.tickIn   = t;
        bus.ackIn    = a;
        model_apply(l, t, a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.lightsIn = RED;
        bus.tickIn   = 1'b0;
        bus.ackIn    = 1'b0;
        #2;
        globalReset = 1'b1;
        q.delete();
        #1;
        chk("rst_lights", 32'(bus.lightsOut), 32'(RED));
        chk("rst_fault",  32'(bus.faultOut),  32'd0);
        chk("rst_code",   32'(bus.faultCode), 32'd0);
        m_fault = 1'b0;
        m_on    = 1'b0;
        m_code  = 0;
        m_filt  = 0;
        m_stuck = 0;
        m_last  = RED;
        m_out   = RED;
        @(negedge clk);
        #1;
        globalReset = 1'b0;
        #1;
        chk("rel_lights", 32'(bus.lightsOut), 32'(RED));
        chk("rel_fault",  32'(bus.faultOut),  32'd0);
        model_apply(RED, 1'b0, 1'b0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("lightsOut", 32'(bus.lightsOut), 32'(e.lights));
                chk("faultOut",  32'(bus.faultOut),  32'(e.fault));
                chk("faultCode", 32'(bus.faultCode), 32'(e.code));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout t=%0t got running want finished", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] cur;
        logic [6:0] v;
        int         ticks;
        int         hold;
        bit         t;
        bit         a;

        pool[0] = MAIN_G;   pool[1] = MAIN_Y;    pool[2] = RED;
        pool[3] = 7'b0011000; pool[4] = 7'b0010100; pool[5] = 7'b0010011;
        pool[6] = BOTH_G;
        bus.lightsIn = RED;
        bus.tickIn   = 1'b0;
        bus.ackIn    = 1'b0;

        do_reset();

        repeat (3) step(MAIN_G, 1'b0, 1'b0);
        repeat (3) step(MAIN_Y, 1'b0, 1'b0);

        cur   = MAIN_G;
        ticks = 0;
        for (int i = 0; i < 200; i++) begin
            t = (i % 2 == 1);
            step(cur, t, 1'b0);
            if (t) begin
                ticks++;
                if (ticks % 10 == 0) cur = (cur == MAIN_G) ? MAIN_Y : MAIN_G;
            end
        end

        // Short conflict filtered out, then a sustained one latches.
        repeat (3) step(BOTH_G, 1'b0, 1'b0);
        step(MAIN_G, 1'b0, 1'b0);
        repeat (4) step(BOTH_G, 1'b0, 1'b0);
        step(BOTH_G, 1'b1, 1'b0);
        step(BOTH_G, 1'b0, 1'b0);
        step(BOTH_G, 1'b1, 1'b0);
        step(BOTH_G, 1'b1, 1'b0);
        step(BOTH_G, 1'b0, 1'b1);
        step(7'b0010011, 1'b0, 1'b1);
        step(7'b0010011, 1'b0, 1'b0);

        // Head invalid, then ack coinciding with a tick.
        repeat (4) step(7'b1100010, 1'b0, 1'b0);
        step(7'b0000010, 1'b1, 1'b0);
        step(MAIN_G, 1'b1, 1'b1);
        step(MAIN_G, 1'b0, 1'b1);

        // Walk unsafe, then conflict outranking head-invalid.
        repeat (4) step(7'b1000011, 1'b0, 1'b0);
        step(RED, 1'b0, 1'b1);
        repeat (4) step(7'b1101000, 1'b0, 1'b0);
        step(RED, 1'b0, 1'b1);

        // Reset mid-filter and mid-fault.
        repeat (2) step(BOTH_G, 1'b0, 1'b0);
        do_reset();
        repeat (4) step(BOTH_G, 1'b0, 1'b0);
        step(BOTH_G, 1'b1, 1'b0);
        do_reset();

        // Stuck watchdog fires after the 120th unchanged tick.
        step(MAIN_G, 1'b0, 1'b0);
        repeat (MAX_T) step(MAIN_G, 1'b1, 1'b0);
        repeat (3) step(MAIN_G, 1'b0, 1'b0);
        step(MAIN_G, 1'b0, 1'b1);
        repeat (MAX_T - 1) step(MAIN_G, 1'b1, 1'b0);
        step(MAIN_Y, 1'b0, 1'b0);
        repeat (MAX_T - 1) step(MAIN_Y, 1'b1, 1'b0);
        repeat (3) step(MAIN_Y, 1'b0, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 4) == 0) v = 7'($urandom_range(0, 127));
            else v = pool[$urandom_range(0, 6)];
            hold = $urandom_range(1, 6);
            for (int k = 0; k < hold; k++) begin
                t = ($urandom_range(0, 3) == 0);
                a = ($urandom_range(0, 7) == 0);
                step(v, t, a);
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
